// File: rtl/crack_scheduler_pkg.sv
// Shared types and default widths for the password-cracking scheduler.
package crack_pkg;

  localparam int MAX_CHARS  = 8;
  localparam int LEN_W      = $clog2(MAX_CHARS) + 1;
  localparam int DEF_PW_W   = 128;
  localparam int DEF_HASH_W = 128;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FOUND,
    ST_EXHAUSTED
  } state_t;

endpackage

// File: rtl/crack_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last-granted one.
// The pointer moves only when the grant is actually consumed (advance).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] grant_idx;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N);
  endfunction

  // Search from farthest to nearest so the nearest requester after ptr wins.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    for (int k = N; k >= 1; k--) begin
      if (req[wrap(int'(ptr) + k)]) begin
        grant                       = '0;
        grant[wrap(int'(ptr) + k)]  = 1'b1;
        grant_idx                   = wrap(int'(ptr) + k);
      end
    end
  end

  // Pointer starts at the last lane so lane 0 is served first after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= IW'(N - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/crack_scheduler.sv
// Dispatches generator candidates round-robin to idle hash lanes, compares
// returned digests against the target, and stops on a match or exhaustion.
module crack_scheduler
  import crack_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int PW_W   = DEF_PW_W,
  parameter int HASH_W = DEF_HASH_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [HASH_W-1:0]       target_hash,
  output logic                    gen_enable,
  input  logic                    cand_valid,
  input  logic [PW_W-1:0]         cand_data,
  input  logic [LEN_W-1:0]        cand_len,
  input  logic                    cand_last,
  output logic                    cand_ready,
  output logic [LANES-1:0]        lane_start,
  output logic [PW_W-1:0]         lane_data,
  input  logic [LANES-1:0]        lane_done,
  input  logic [LANES*HASH_W-1:0] lane_hash,
  output logic                    lane_abort,
  output logic                    busy,
  output logic                    found,
  output logic                    exhausted,
  output logic [PW_W-1:0]         found_password,
  output logic [LEN_W-1:0]        found_len,
  output logic [CNT_W-1:0]        tried_count
);

  localparam int LI = (LANES > 1) ? $clog2(LANES) : 1;

  state_t             state;
  logic [HASH_W-1:0]  target;
  logic [LANES-1:0]   lane_busy;
  logic [PW_W-1:0]    shadow_pw  [LANES];
  logic [LEN_W-1:0]   shadow_len [LANES];

  logic               active;
  logic               match_any;
  logic [LI-1:0]      match_idx;
  logic [LANES-1:0]   req;
  logic [LANES-1:0]   grant;
  logic               handshake;
  logic [CNT_W:0]     done_cnt;
  logic [CNT_W:0]     count_sum;
  logic [CNT_W-1:0]   count_next;

  assign active = (state == ST_RUN) || (state == ST_DRAIN);

  // A lane finishing this cycle can be refilled in the same cycle.
  assign req        = ~lane_busy | lane_done;
  // Hold off acceptance when the search is about to stop, so no candidate is lost.
  assign cand_ready = (state == ST_RUN) && (|req) && !match_any && !abort;
  assign handshake  = cand_valid && cand_ready;

  rr_arbiter #(.N(LANES)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .advance (handshake),
    .grant   (grant)
  );

  // Priority match encoder: lowest matching lane index wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (active && lane_done[i] && (lane_hash[i*HASH_W +: HASH_W] == target)) begin
        match_any = 1'b1;
        match_idx = LI'(i);
      end
    end
  end

  // Saturating add of the number of digests returned this cycle.
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      done_cnt = done_cnt + (CNT_W + 1)'(lane_done[i]);
    end
    count_sum  = {1'b0, tried_count} + done_cnt;
    count_next = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
  end

  // Per-lane shadow of the candidate in flight, captured on dispatch.
  // NOTE: plain storage with no reset; contents are only read after a write.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (handshake && grant[i]) begin
        shadow_pw[i]  <= cand_data;
        shadow_len[i] <= cand_len;
      end
    end
  end

  // Search FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      target         <= '0;
      lane_busy      <= '0;
      gen_enable     <= 1'b0;
      lane_start     <= '0;
      lane_data      <= '0;
      lane_abort     <= 1'b0;
      busy           <= 1'b0;
      found          <= 1'b0;
      exhausted      <= 1'b0;
      found_password <= '0;
      found_len      <= '0;
      tried_count    <= '0;
    end else begin
      lane_start <= '0;
      lane_abort <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        lane_busy  <= '0;
        lane_abort <= 1'b1;
        busy       <= 1'b0;
        gen_enable <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
            if (start) begin
              state          <= ST_RUN;
              target         <= target_hash;
              lane_busy      <= '0;
              tried_count    <= '0;
              found          <= 1'b0;
              exhausted      <= 1'b0;
              found_password <= '0;
              found_len      <= '0;
              busy           <= 1'b1;
              gen_enable     <= 1'b1;
            end
          end
          ST_RUN, ST_DRAIN: begin
            tried_count <= count_next;
            if (match_any) begin
              state          <= ST_FOUND;
              found          <= 1'b1;
              found_password <= shadow_pw[match_idx];
              found_len      <= shadow_len[match_idx];
              lane_abort     <= 1'b1;
              lane_busy      <= '0;
              busy           <= 1'b0;
              gen_enable     <= 1'b0;
            end else begin
              lane_busy <= (lane_busy & ~lane_done) | (handshake ? grant : '0);
              if (handshake) begin
                lane_start <= grant;
                lane_data  <= cand_data;
              end
              if (state == ST_RUN && handshake && cand_last) begin
                state      <= ST_DRAIN;
                gen_enable <= 1'b0;
              end
              if (state == ST_DRAIN && lane_busy == '0) begin
                state     <= ST_EXHAUSTED;
                exhausted <= 1'b1;
                busy      <= 1'b0;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crack_scheduler.sv
// Directed self-checking bench for crack_scheduler with a small generator
// model and a fixed-latency hash-engine model.
module tb_crack_scheduler;
  import crack_pkg::*;

  localparam int LANES   = 4;
  localparam int PW_W    = 128;
  localparam int HASH_W  = 128;
  localparam int CNT_W   = 32;
  localparam int ENG_LAT = 5;
  localparam logic [127:0] HKEY = {4{32'hDEADBEEF}};

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic [HASH_W-1:0]       target_hash = '0;
  logic                    gen_enable;
  logic                    cand_valid = 1'b0;
  logic [PW_W-1:0]         cand_data = '0;
  logic [LEN_W-1:0]        cand_len = '0;
  logic                    cand_last = 1'b0;
  logic                    cand_ready;
  logic [LANES-1:0]        lane_start;
  logic [PW_W-1:0]         lane_data;
  logic [LANES-1:0]        lane_done = '0;
  logic [LANES*HASH_W-1:0] lane_hash = '0;
  logic                    lane_abort;
  logic                    busy;
  logic                    found;
  logic                    exhausted;
  logic [PW_W-1:0]         found_password;
  logic [LEN_W-1:0]        found_len;
  logic [CNT_W-1:0]        tried_count;

  crack_scheduler #(.LANES(LANES), .PW_W(PW_W), .HASH_W(HASH_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .target_hash(target_hash), .gen_enable(gen_enable),
    .cand_valid(cand_valid), .cand_data(cand_data), .cand_len(cand_len),
    .cand_last(cand_last), .cand_ready(cand_ready),
    .lane_start(lane_start), .lane_data(lane_data), .lane_done(lane_done),
    .lane_hash(lane_hash), .lane_abort(lane_abort), .busy(busy),
    .found(found), .exhausted(exhausted), .found_password(found_password),
    .found_len(found_len), .tried_count(tried_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Generator model
  logic [127:0]     gen_pw [8];
  logic [LEN_W-1:0] gen_ln [8];
  int               gen_n = 0;
  int               gen_idx = 0;
  bit               hs_pending = 1'b0;

  // Hash-engine model
  bit               auto_eng = 1'b1;
  logic [LANES-1:0] man_done = '0;
  int               eng_cnt [LANES];
  logic [127:0]     eng_pw  [LANES];
  int               grant_log [$];
  int               abort_cnt = 0;

  function automatic logic [127:0] h(input logic [127:0] x);
    return x ^ HKEY;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: at the falling edge observe outputs, step both models, drive inputs.
  task automatic tick();
    @(negedge clock);
    if (lane_abort === 1'b1) begin
      abort_cnt++;
      for (int i = 0; i < LANES; i++) eng_cnt[i] = 0;
    end
    lane_done = '0;
    if (auto_eng) begin
      for (int i = 0; i < LANES; i++) begin
        if (eng_cnt[i] > 0) begin
          eng_cnt[i]--;
          if (eng_cnt[i] == 0) begin
            lane_done[i] = 1'b1;
            lane_hash[i*HASH_W +: HASH_W] = h(eng_pw[i]);
          end
        end
      end
    end else begin
      lane_done = man_done;
      man_done  = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      if (lane_start[i] === 1'b1) begin
        grant_log.push_back(i);
        eng_pw[i]  = lane_data;
        eng_cnt[i] = ENG_LAT;
      end
    end
    if (hs_pending) gen_idx++;
    if (gen_enable === 1'b1 && gen_idx < gen_n) begin
      cand_valid = 1'b1;
      cand_data  = gen_pw[gen_idx];
      cand_len   = gen_ln[gen_idx];
      cand_last  = (gen_idx == gen_n - 1);
    end else begin
      cand_valid = 1'b0;
      cand_last  = 1'b0;
    end
    #1;
    hs_pending = (cand_valid === 1'b1) && (cand_ready === 1'b1);
  endtask

  task automatic setup(input logic [127:0] base, input int n, input logic [LEN_W-1:0] len,
                       input logic [127:0] tgt);
    for (int k = 0; k < n; k++) begin
      gen_pw[k] = base + 128'(k);
      gen_ln[k] = len;
    end
    gen_n      = n;
    gen_idx    = 0;
    hs_pending = 1'b0;
    grant_log.delete();
    abort_cnt  = 0;
    for (int i = 0; i < LANES; i++) eng_cnt[i] = 0;
    target_hash = h(tgt);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(found === 1'b1 || exhausted === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 1'(found === 1'b1 || exhausted === 1'b1), 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_gen"},   gen_enable, 1'b0);
    check({tag, "_ready"}, cand_ready, 1'b0);
    check({tag, "_lst"},   lane_start, '0);
    check({tag, "_ldat"},  lane_data, '0);
    check({tag, "_labt"},  lane_abort, 1'b0);
    check({tag, "_fnd"},   found, 1'b0);
    check({tag, "_exh"},   exhausted, 1'b0);
    check({tag, "_fpw"},   found_password, '0);
    check({tag, "_flen"},  found_len, '0);
    check({tag, "_cnt"},   tried_count, '0);
  endtask

  initial begin
    for (int i = 0; i < LANES; i++) eng_cnt[i] = 0;

    // Reset state
    repeat (2) tick();
    check_all_zero("rst");
    reset_n = 1'b1;
    tick();

    // 1: eight candidates, no match, fixed latency
    auto_eng = 1'b1;
    setup(128'h30, 8, 4'd1, 128'hFFFF);
    pulse_start();
    check("t1_busy", busy, 1'b1);
    check("t1_gen",  gen_enable, 1'b1);
    wait_end("t1_timeout", 200);
    check("t1_exh",   exhausted, 1'b1);
    check("t1_fnd",   found, 1'b0);
    check("t1_cnt",   tried_count, 32'd8);
    check("t1_busy0", busy, 1'b0);
    check("t1_nlog",  grant_log.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t1_order%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, i % 4);

    // 2: fifth candidate "abc" matches
    setup(128'h30, 8, 4'd1, 128'h636261);
    gen_pw[4] = 128'h636261;
    gen_ln[4] = 4'd3;
    pulse_start();
    check("t2_exh_clr", exhausted, 1'b0);
    check("t2_cnt_clr", tried_count, 32'd0);
    wait_end("t2_timeout", 200);
    check("t2_fnd",  found, 1'b1);
    check("t2_gen",  gen_enable, 1'b0);
    check("t2_labt", lane_abort, 1'b1);
    check("t2_pw24", found_password[23:0], 24'h636261);
    check("t2_pw",   found_password, 128'h636261);
    check("t2_len",  found_len, 4'd3);
    check("t2_cnt",  tried_count, 32'd5);
    check("t2_busy", busy, 1'b0);
    repeat (3) tick();
    check("t2_nabort", abort_cnt, 1);

    // 3: all lanes busy, candidate held; freed lane re-granted same cycle
    auto_eng  = 1'b0;
    lane_hash = '0;
    setup(128'h4100, 6, 4'd2, 128'h77);
    pulse_start();
    repeat (6) tick();
    check("t3_nlog",  grant_log.size(), 4);
    check("t3_valid", cand_valid, 1'b1);
    check("t3_nrdy",  cand_ready, 1'b0);
    man_done = 4'b0100;
    tick();
    check("t3_rdy",   cand_ready, 1'b1);
    tick();
    check("t3_lst",   lane_start, 4'b0100);
    check("t3_ldat",  lane_data, 128'h4104);
    check("t3_cnt",   tried_count, 32'd1);

    // 4: lanes 1 and 3 match together; lowest index wins
    lane_hash[1*HASH_W +: HASH_W] = h(128'h77);
    lane_hash[3*HASH_W +: HASH_W] = h(128'h77);
    man_done = 4'b1010;
    tick();
    tick();
    check("t4_fnd",  found, 1'b1);
    check("t4_pw",   found_password, 128'h4101);
    check("t4_len",  found_len, 4'd2);
    check("t4_cnt",  tried_count, 32'd3);
    check("t4_labt", lane_abort, 1'b1);

    // 5: abort during DRAIN with three lanes busy
    lane_hash = '0;
    setup(128'h5200, 3, 4'd2, 128'h77);
    pulse_start();
    repeat (3) tick();
    check("t5_busy",  busy, 1'b1);
    check("t5_gen",   gen_enable, 1'b0);
    check("t5_rdy",   cand_ready, 1'b0);
    check("t5_nlog",  grant_log.size(), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle",  busy, 1'b0);
    check("t5_labt",  lane_abort, 1'b1);
    check("t5_fnd",   found, 1'b0);
    check("t5_exh",   exhausted, 1'b0);
    man_done = 4'b1111;
    tick();
    tick();
    check("t5_cnt",   tried_count, 32'd0);
    check("t5_labt1", abort_cnt, 1);

    // 6: asynchronous reset mid-RUN, then restart from lane 0
    auto_eng = 1'b1;
    setup(128'h30, 8, 4'd1, 128'hFFFF);
    pulse_start();
    repeat (3) tick();
    check("t6_busy_pre", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    setup(128'h30, 8, 4'd1, 128'hFFFF);
    gen_n = 0;
    tick();
    reset_n = 1'b1;
    setup(128'h30, 8, 4'd1, 128'hFFFF);
    pulse_start();
    tick();
    check("t6_lst",   lane_start, 4'b0001);
    check("t6_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
